// File: rtl/sound_cmd_sequencer.sv
// Sound command sequencer: captures CPU writes to the sound latch, applies
// them on the 3 MHz enable, decodes them per game mode into the analog
// datapath controls and fades the master gain on global enable/disable.
module sound_cmd_sequencer #(
    parameter int unsigned GAIN_W    = 8,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_3MHz_en,
    input  logic              clk_12KHz_en,
    input  logic              mod_redbaron,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              sound_enable,
    output logic              motor_en,
    output logic              engine_rev_en,
    output logic              shell_ls,
    output logic              shell_en,
    output logic              explo_ls,
    output logic              explo_en,
    output logic [3:0]        crsh,
    output logic              shell_trig,
    output logic              explo_trig,
    output logic [GAIN_W-1:0] master_gain
);

    localparam int unsigned       SUM_W    = GAIN_W + 1;
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
    localparam logic [SUM_W-1:0]  STEP_EXT = SUM_W'(RAMP_STEP);

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } fade_state_t;

    fade_state_t       state, state_nxt;
    logic [GAIN_W-1:0] gain_nxt;
    logic [SUM_W-1:0]  gain_up, gain_dn;
    logic [7:0]        pend_data, latch, latch_nxt;
    logic              pend_valid, mode_q, mode_nxt;
    logic              apply, mode_chg, req, gate_nxt;
    logic              motor_nxt, rev_nxt, shell_ls_nxt, shell_nxt;
    logic              explo_ls_nxt, explo_nxt;
    logic [3:0]        crsh_nxt;
    logic              unused_b6;

    // Bit 6 has no function in either game mode.
    assign unused_b6 = latch[6];

    assign mode_chg = clk_3MHz_en && (mod_redbaron != mode_q);
    assign apply    = clk_3MHz_en && pend_valid;
    assign req      = latch[5];
    assign gain_up  = {1'b0, master_gain} + STEP_EXT;
    assign gain_dn  = {1'b0, master_gain} - STEP_EXT;
    assign mode_nxt = clk_3MHz_en ? mod_redbaron : mode_q;
    assign gate_nxt = (state_nxt != MUTED);

    // Latch update: mode change acts as a soft clear, otherwise apply pending.
    always_comb begin
        latch_nxt = latch;
        if (mode_chg) begin
            latch_nxt = 8'h00;
        end else if (apply) begin
            latch_nxt = pend_data;
        end
    end

    // Pending write buffer, applied latch and detected game mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data  <= 8'h00;
            pend_valid <= 1'b0;
            latch      <= 8'h00;
            mode_q     <= 1'b0;
        end else begin
            latch  <= latch_nxt;
            mode_q <= mode_nxt;
            if (mode_chg) begin
                pend_data  <= 8'h00;
                pend_valid <= 1'b0;
            end else if (wr_en) begin
                pend_data  <= wr_data;
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Fade FSM next state and gain, stepping only on 12 kHz ticks.
    always_comb begin
        state_nxt = state;
        gain_nxt  = master_gain;
        if (clk_12KHz_en) begin
            unique case (state)
                MUTED: begin
                    gain_nxt = '0;
                    if (req) state_nxt = RAMP_UP;
                end
                RAMP_UP: begin
                    if (!req) begin
                        state_nxt = RAMP_DOWN;
                    end else if (gain_up >= {1'b0, GAIN_MAX}) begin
                        gain_nxt  = GAIN_MAX;
                        state_nxt = ACTIVE;
                    end else begin
                        gain_nxt = gain_up[GAIN_W-1:0];
                    end
                end
                ACTIVE: begin
                    gain_nxt = GAIN_MAX;
                    if (!req) state_nxt = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (req) begin
                        state_nxt = RAMP_UP;
                    end else if ({1'b0, master_gain} <= STEP_EXT) begin
                        gain_nxt  = '0;
                        state_nxt = MUTED;
                    end else begin
                        gain_nxt = gain_dn[GAIN_W-1:0];
                    end
                end
                default: begin
                    gain_nxt  = '0;
                    state_nxt = MUTED;
                end
            endcase
        end
        if (mode_chg) begin
            state_nxt = MUTED;
            gain_nxt  = '0;
        end
    end

    // Fade FSM state and gain registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MUTED;
            master_gain <= '0;
        end else begin
            state       <= state_nxt;
            master_gain <= gain_nxt;
        end
    end

    // Mode-dependent decode of the next latch value, gated while muted.
    always_comb begin
        motor_nxt    = 1'b0;
        rev_nxt      = 1'b0;
        shell_ls_nxt = 1'b0;
        shell_nxt    = 1'b0;
        explo_ls_nxt = 1'b0;
        explo_nxt    = 1'b0;
        crsh_nxt     = 4'h0;
        if (!mode_nxt) begin
            motor_nxt    = gate_nxt & latch_nxt[7];
            rev_nxt      = latch_nxt[4];
            shell_ls_nxt = latch_nxt[2];
            shell_nxt    = gate_nxt & latch_nxt[3];
            explo_ls_nxt = latch_nxt[0];
            explo_nxt    = gate_nxt & latch_nxt[1];
        end else begin
            shell_nxt = gate_nxt & latch_nxt[4];
            crsh_nxt  = gate_nxt ? latch_nxt[3:0] : 4'h0;
        end
    end

    // Registered datapath controls and rising-edge retrigger pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sound_enable  <= 1'b0;
            motor_en      <= 1'b0;
            engine_rev_en <= 1'b0;
            shell_ls      <= 1'b0;
            shell_en      <= 1'b0;
            explo_ls      <= 1'b0;
            explo_en      <= 1'b0;
            crsh          <= 4'h0;
            shell_trig    <= 1'b0;
            explo_trig    <= 1'b0;
        end else begin
            sound_enable  <= gate_nxt;
            motor_en      <= motor_nxt;
            engine_rev_en <= rev_nxt;
            shell_ls      <= shell_ls_nxt;
            shell_en      <= shell_nxt;
            explo_ls      <= explo_ls_nxt;
            explo_en      <= explo_nxt;
            crsh          <= crsh_nxt;
            shell_trig    <= shell_nxt & ~shell_en;
            explo_trig    <= explo_nxt & ~explo_en;
        end
    end

endmodule
